// File: rtl/nano5_mem_port.sv
// nano5_mem_port: Avalon-MM slave for the nano5 core with word RAM, an I/O page and an interval timer.
// Define NANO5_MEM_TIMER_EN to build the timer/IO registers; otherwise the I/O page is a hole and irq is 0.
module nano5_mem_port #(
  parameter int WIDTHA   = 12,
  parameter int WIDTHD   = 32,
  parameter int RAMDEPTH = 2048,
  parameter int IOBASE   = 'hff0
) (
  input  logic                clock,
  input  logic                sreset_n,
  input  logic [WIDTHA-1:0]   address,
  input  logic [WIDTHD-1:0]   writedata,
  output logic [WIDTHD-1:0]   readdata,
  input  logic [WIDTHD/8-1:0] byteenable,
  input  logic                read,
  input  logic                write,
  output logic                waitrequest,
  output logic                irq
);
  localparam int RAW = $clog2(RAMDEPTH);
  localparam int NB  = WIDTHD / 8;

  typedef enum logic {IDLE, RDWAIT} state_t;
  state_t state_q, state_d;

  logic [WIDTHD-1:0] mem [RAMDEPTH];
  logic [WIDTHD-1:0] ram_rd_q;
  logic              is_ram;
  logic              rd_ram;
  logic [RAW-1:0]    ram_idx;

  assign is_ram  = ({1'b0, address} < (WIDTHA+1)'(RAMDEPTH));
  assign rd_ram  = read & ~write & is_ram;
  assign ram_idx = address[RAW-1:0];

  always_comb begin
    state_d     = state_q;
    waitrequest = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_ram) begin
          state_d     = RDWAIT;
          waitrequest = 1'b1;
        end
      end
      RDWAIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!sreset_n) waitrequest = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!sreset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // RAM has no reset so its contents survive sreset_n.
  always_ff @(posedge clock) begin
    if (sreset_n && write && is_ram) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) mem[ram_idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
    if (sreset_n && (state_q == IDLE) && rd_ram) ram_rd_q <= mem[ram_idx];
  end

`ifdef NANO5_MEM_TIMER_EN
  logic              is_io;
  logic              io_wr;
  logic              expire;
  logic [3:0]        io_idx;
  logic              run_q, run_d, auto_q, auto_d, ie_q, ie_d, pend_q, pend_d, irq_q;
  logic [WIDTHD-1:0] reload_q, reload_d, count_q, count_d, io_rdata;

  assign is_io  = (address >= WIDTHA'(IOBASE));
  assign io_idx = address[3:0];
  assign io_wr  = write & is_io;

  always_comb begin
    run_d    = run_q;
    auto_d   = auto_q;
    ie_d     = ie_q;
    reload_d = reload_q;
    count_d  = count_q;
    pend_d   = pend_q;
    expire   = run_q && (count_q == '0);
    if (run_q) begin
      if (!expire)     count_d = count_q - WIDTHD'(1);
      else if (auto_q) count_d = reload_q;
      else             run_d   = 1'b0;
    end
    // CPU writes override the timer's own update; only PEND set beats a CPU clear.
    if (io_wr) begin
      case (io_idx)
        4'd0: begin
          run_d  = writedata[0];
          auto_d = writedata[1];
          ie_d   = writedata[2];
        end
        4'd1: reload_d = writedata;
        4'd2: count_d  = writedata;
        4'd3: if (writedata[0]) pend_d = 1'b0;
        default: ;
      endcase
    end
    if (expire) pend_d = 1'b1;
  end

  always_comb begin
    io_rdata = '0;
    case (io_idx)
      4'd0:    io_rdata = WIDTHD'({ie_q, auto_q, run_q});
      4'd1:    io_rdata = reload_q;
      4'd2:    io_rdata = count_q;
      4'd3:    io_rdata = WIDTHD'(pend_q);
      default: io_rdata = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!sreset_n) begin
      run_q    <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      reload_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      run_q    <= run_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= pend_q & ie_q;
    end
  end

  assign irq = irq_q & sreset_n;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    if (sreset_n && !write) begin
      if (state_q == RDWAIT) readdata = ram_rd_q;
`ifdef NANO5_MEM_TIMER_EN
      else if (read && is_io) readdata = io_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_nano5_mem_port.sv
// Self-checking bench for nano5_mem_port: vector table, hand-written corner sequences, random ops vs a RAM model.
module tb_nano5_mem_port;
  localparam int          RAMDEPTH = 2048;
  localparam logic [11:0] IO       = 12'hff0;

  logic        clock = 1'b0;
  logic        sreset_n;
  logic [11:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic        irq;

  nano5_mem_port dut (
    .clock(clock), .sreset_n(sreset_n), .address(address), .writedata(writedata),
    .readdata(readdata), .byteenable(byteenable), .read(read), .write(write),
    .waitrequest(waitrequest), .irq(irq)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [RAMDEPTH];

  typedef struct {
    bit          wr;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [31:0] exp;
    int          waits;
  } vec_t;
  vec_t vt [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
    #1;
    chk("wr_wait", 32'(waitrequest), 32'd0);
    step();
    write = 1'b0;
    if (a < 12'(RAMDEPTH))
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[a[10:0]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output int waits);
    address = a; read = 1'b1; write = 1'b0; waits = 0; d = '0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (!waitrequest) begin
        d = readdata;
        break;
      end
      waits++;
      step();
    end
    if (waits >= 4) chk("rd_timeout", 32'(waits), 32'd1);
    step();
    read = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp, input int exp_w);
    logic [31:0] d;
    int w;
    do_read(a, d, w);
    chk({name, "_data"}, d, exp);
    chk({name, "_wait"}, 32'(w), 32'(exp_w));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] pool [16];
    logic [11:0] a;
    logic [31:0] d;
    int r;

    vt[0]  = '{1'b1, 12'h004, 32'hdeadbeef, 4'hf,    32'h0,        0};
    vt[1]  = '{1'b0, 12'h004, 32'h0,        4'h0,    32'hdeadbeef, 1};
    vt[2]  = '{1'b1, 12'h4e1, 32'h11223344, 4'hf,    32'h0,        0};
    vt[3]  = '{1'b1, 12'h4e1, 32'hffffffff, 4'b0101, 32'h0,        0};
    vt[4]  = '{1'b0, 12'h4e1, 32'h0,        4'h0,    32'h11ff33ff, 1};
    vt[5]  = '{1'b0, 12'h900, 32'h0,        4'h0,    32'h0,        0};
    vt[6]  = '{1'b1, 12'h900, 32'h12345678, 4'hf,    32'h0,        0};
    vt[7]  = '{1'b0, 12'h900, 32'h0,        4'h0,    32'h0,        0};
    vt[8]  = '{1'b1, 12'h7ff, 32'ha5a5a5a5, 4'hf,    32'h0,        0};
    vt[9]  = '{1'b0, 12'h7ff, 32'h0,        4'h0,    32'ha5a5a5a5, 1};
    vt[10] = '{1'b1, 12'h4ff, 32'h12345678, 4'hf,    32'h0,        0};
    vt[11] = '{1'b1, 12'h4ff, 32'h0000beef, 4'b0011, 32'h0,        0};
    vt[12] = '{1'b0, 12'h4ff, 32'h0,        4'h0,    32'h1234beef, 1};
    vt[13] = '{1'b0, 12'h800, 32'h0,        4'h0,    32'h0,        0};
    vt[14] = '{1'b0, 12'hffe, 32'h0,        4'h0,    32'h0,        0};
    vt[15] = '{1'b0, 12'h004, 32'h0,        4'h0,    32'hdeadbeef, 1};

    sreset_n = 1'b0; address = '0; writedata = '0; byteenable = '0; read = 1'b0; write = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    read = 1'b1; address = 12'h004;
    #1;
    chk("rst_wait", 32'(waitrequest), 32'd1);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    step();
    read = 1'b0;
    sreset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) do_write(vt[i].a, vt[i].d, vt[i].be);
      else          rd_chk($sformatf("vec%0d", i), vt[i].a, vt[i].exp, vt[i].waits);
    end

    // read and write together: write wins, no wait, readdata 0
    address = 12'h010; writedata = 32'hcafef00d; byteenable = 4'hf; read = 1'b1; write = 1'b1;
    #1;
    chk("rw_wait", 32'(waitrequest), 32'd0);
    chk("rw_rdata", readdata, 32'd0);
    step();
    read = 1'b0; write = 1'b0;
    mdl[12'h010] = 32'hcafef00d;
    rd_chk("rw_after", 12'h010, 32'hcafef00d, 1);

`ifdef NANO5_MEM_TIMER_EN
    // auto-reload period of RELOAD+1 clocks
    do_write(IO + 12'd1, 32'd3, 4'hf);
    do_write(IO + 12'd2, 32'd3, 4'hf);
    do_write(IO + 12'd0, 32'd7, 4'hf);
    address = IO + 12'd2; read = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("auto_cnt%0d", k), readdata, 32'(3 - (k % 4)));
      chk($sformatf("auto_irq%0d", k), 32'(irq), 32'(k >= 5));
      @(posedge clock);
      #1;
    end
    read = 1'b0;
    do_write(IO + 12'd0, 32'd4, 4'hf);
    do_write(IO + 12'd3, 32'd1, 4'hf);
    #1;
    chk("clr_irq_hold", 32'(irq), 32'd1);
    step();
    #1;
    chk("clr_irq_drop", 32'(irq), 32'd0);
    step();

    // one-shot
    do_write(IO + 12'd2, 32'd2, 4'hf);
    do_write(IO + 12'd0, 32'd5, 4'hf);
    repeat (6) step();
    rd_chk("os_ctrl", IO + 12'd0, 32'd4, 0);
    rd_chk("os_count", IO + 12'd2, 32'd0, 0);
    rd_chk("os_pend", IO + 12'd3, 32'd1, 0);
    chk("os_irq", 32'(irq), 32'd1);
    do_write(IO + 12'd3, 32'd1, 4'hf);
    #1;
    chk("os_irq_hold", 32'(irq), 32'd1);
    step();
    #1;
    chk("os_irq_drop", 32'(irq), 32'd0);
    step();

    // STATUS clear on the expiry edge: set wins
    do_write(IO + 12'd2, 32'd2, 4'hf);
    do_write(IO + 12'd0, 32'd5, 4'hf);
    step();
    step();
    do_write(IO + 12'd3, 32'd1, 4'hf);
    rd_chk("coll_pend", IO + 12'd3, 32'd1, 0);
    do_write(IO + 12'd3, 32'd1, 4'hf);
    rd_chk("coll_clr", IO + 12'd3, 32'd0, 0);

    // COUNT write beats decrement
    do_write(IO + 12'd2, 32'd5, 4'hf);
    do_write(IO + 12'd0, 32'd1, 4'hf);
    do_write(IO + 12'd2, 32'd9, 4'hf);
    address = IO + 12'd2; read = 1'b1;
    #1;
    chk("cw_count", readdata, 32'd9);
    step();
    #1;
    chk("cw_dec", readdata, 32'd8);
    step();
    read = 1'b0;
    do_write(IO + 12'd0, 32'd0, 4'hf);
`else
    // without the timer the I/O page is a hole
    do_write(IO + 12'd1, 32'd3, 4'hf);
    do_write(IO + 12'd2, 32'd3, 4'hf);
    do_write(IO + 12'd0, 32'd7, 4'hf);
    rd_chk("noio_ctrl", IO + 12'd0, 32'd0, 0);
    rd_chk("noio_count", IO + 12'd2, 32'd0, 0);
    repeat (8) step();
    chk("noio_irq", 32'(irq), 32'd0);
`endif

    // reset while a read is in its wait state
    address = 12'h004; read = 1'b1; write = 1'b0;
    #1;
    chk("rdw_wait0", 32'(waitrequest), 32'd1);
    step();
    sreset_n = 1'b0;
    #1;
    chk("rdw_rst_wait", 32'(waitrequest), 32'd1);
    chk("rdw_rst_irq", 32'(irq), 32'd0);
    chk("rdw_rst_rdata", readdata, 32'd0);
    step();
    read = 1'b0;
    sreset_n = 1'b1;
    rd_chk("rdw_after", 12'h004, 32'hdeadbeef, 1);

    // random traffic against the word-array model
    for (int i = 0; i < 16; i++) begin
      pool[i] = 12'h100 + 12'(i * 37);
      do_write(pool[i], $urandom, 4'hf);
    end
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 15)];
      if (r <= 3) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)));
      end else if (r <= 6) begin
        rd_chk("rnd_ram", a, mdl[a[10:0]], 1);
      end else if (r == 7) begin
        do_write(12'(RAMDEPTH + $urandom_range(0, 'hff0 - RAMDEPTH - 1)), $urandom, 4'hf);
      end else if (r == 8) begin
        rd_chk("rnd_hole", 12'(RAMDEPTH + $urandom_range(0, 'hff0 - RAMDEPTH - 1)), 32'd0, 0);
      end else begin
`ifdef NANO5_MEM_TIMER_EN
        rd_chk("rnd_ram2", a, mdl[a[10:0]], 1);
`else
        rd_chk("rnd_io", IO + 12'($urandom_range(0, 15)), 32'd0, 0);
`endif
      end
    end
    for (int i = 0; i < 16; i++) begin
      d = mdl[pool[i][10:0]];
      rd_chk($sformatf("final%0d", i), pool[i], d, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
